// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator.
//   MODE_W : width of the mode select / mode register
//   mode_e : pattern modes selected by the switch input
package led_pattern_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    OFF     = 3'd0,
    ON      = 3'd1,
    ROTL    = 3'd2,
    ROTR    = 3'd3,
    COUNT   = 3'd4,
    BOUNCE  = 3'd5,
    JOHNSON = 3'd6,
    BLINK   = 3'd7
  } mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Step-strobe generator: counts enabled clocks 0..DIV-1 and pulses tick on
// the last count of each period.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   enable : while low the count holds (it is not cleared)
//   clear  : restarts the period; suppresses tick on the same clock
//   tick   : combinational strobe, high on an enabled clock that ends a period
module led_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // A clear always wins: a reload discards a step that would be due.
  assign tick = enable & ~clear & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      if (clear || cnt == LAST) cnt <= '0;
      else                      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: eight selectable patterns stepped every DIV enabled
// clocks. A change of switch reloads the mode's seed on the next enabled edge.
//   N_LED  : LED count / pattern width (2..32)
//   DIV    : enabled clocks per pattern step (1..2^24)
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (priority over everything)
//   enable : while low, all state holds and switch changes are not seen
//   switch : mode select (mode_e), sampled every enabled clock
//   led    : registered pattern output
// Build option: define LED_PATTERN_GRAY_EN to show the COUNT mode as Gray code
// (binary count kept internally, converted into a dedicated output register).
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED = 8,
  parameter int DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [MODE_W-1:0] switch,
  output logic [N_LED-1:0]  led
);

  localparam logic [N_LED-1:0] ALL0 = '0;
  localparam logic [N_LED-1:0] ALL1 = '1;
  localparam logic [N_LED-1:0] LSB  = N_LED'(1);
  localparam logic [N_LED-1:0] MSB  = LSB << (N_LED - 1);

  mode_e            mode_q, mode_n, req;
  logic [N_LED-1:0] pat, pat_n;
  logic             dir, dir_n;   // 0 = shifting toward MSB, 1 = toward bit 0
  logic             reload, tick;

  assign req    = mode_e'(switch);
  assign reload = (req != mode_q);

  led_prescaler #(.DIV(DIV)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (reload),
    .tick   (tick)
  );

  function automatic logic [N_LED-1:0] seed(input mode_e m);
    case (m)
      ON, BLINK:    seed = ALL1;
      ROTL, BOUNCE: seed = LSB;
      ROTR:         seed = MSB;
      default:      seed = ALL0;   // OFF, COUNT, JOHNSON
    endcase
  endfunction

  always_comb begin
    mode_n = mode_q;
    pat_n  = pat;
    dir_n  = dir;
    if (reload) begin
      mode_n = req;
      pat_n  = seed(req);
      dir_n  = 1'b0;
    end else if (tick) begin
      case (mode_q)
        OFF:     pat_n = ALL0;
        ON:      pat_n = ALL1;
        ROTL:    pat_n = {pat[N_LED-2:0], pat[N_LED-1]};
        ROTR:    pat_n = {pat[0], pat[N_LED-1:1]};
        COUNT:   pat_n = pat + LSB;
        BOUNCE: begin
          // Direction flips on the step that lands on an end, so neither end
          // is shown twice in a row.
          if (!dir) begin
            pat_n = pat << 1;
            if (pat_n[N_LED-1]) dir_n = 1'b1;
          end else begin
            pat_n = pat >> 1;
            if (pat_n[0]) dir_n = 1'b0;
          end
        end
        JOHNSON: pat_n = {pat[N_LED-2:0], ~pat[N_LED-1]};
        BLINK:   pat_n = ~pat;
        default: pat_n = pat;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= OFF;
      pat    <= '0;
      dir    <= 1'b0;
    end else if (enable) begin
      mode_q <= mode_n;
      pat    <= pat_n;
      dir    <= dir_n;
    end
  end

`ifdef LED_PATTERN_GRAY_EN
  // Converted from the next-state values so the Gray view has the same
  // one-clock timing as the plain pattern register.
  logic [N_LED-1:0] led_q;

  always_ff @(posedge clk) begin
    if (rst)         led_q <= '0;
    else if (enable) led_q <= (mode_n == COUNT) ? (pat_n ^ (pat_n >> 1)) : pat_n;
  end

  assign led = led_q;
`else
  assign led = pat;
`endif

endmodule
